// File: rtl/npu_fixedpoint_pkg.sv
// Shared fixed-point definitions for the requantization datapath
// (rounding divide-by-POT and saturating multiply-by-POT stages).
package npu_fixedpoint_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_EXP_WIDTH  = 5;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] result;
    logic                          sat;
  } sat_result_t;

endpackage

// File: rtl/sat_shift_left.sv
// Combinational x * 2^exponent with signed saturation to the data width.
module sat_shift_left
  import npu_fixedpoint_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int EXP_WIDTH  = DEFAULT_EXP_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [EXP_WIDTH-1:0]  exponent_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  sat_o
);

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [EXP_WIDTH-1:0]  hi_shamt;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    // For e >= 1 the bound 2^(W-1-e) stays below 2^(W-1), so it never overflows;
    // the lower bound is its two's-complement mirror, -(hi+1) == ~hi.
    hi_shamt = EXP_WIDTH'(DATA_WIDTH - 1) - exponent_i;
    hi       = (DATA_WIDTH'(1) << hi_shamt) - DATA_WIDTH'(1);
    lo       = ~hi;
    result_o = x_i << exponent_i;
    sat_o    = 1'b0;
    if (exponent_i == '0) begin
      result_o = x_i;
    end else if ($signed(x_i) > $signed(hi)) begin
      result_o = MAX_VAL;
      sat_o    = 1'b1;
    end else if ($signed(x_i) < $signed(lo)) begin
      result_o = MIN_VAL;
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/saturating_mul_by_pot_pipe.sv
// Two-stage valid/ready pipeline around sat_shift_left with last passthrough
// and a sticky saturation-event counter.
module saturating_mul_by_pot_pipe
  import npu_fixedpoint_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int EXP_WIDTH     = DEFAULT_EXP_WIDTH,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_x,
  input  logic [EXP_WIDTH-1:0]     in_exponent,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic                     out_saturated,
  output logic                     out_last,
  output logic [SAT_CNT_WIDTH-1:0] sat_count,
  input  logic                     sat_count_clr
);

  logic                     s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]    s1_result_q, s1_result_d;
  logic                     s1_sat_q, s1_sat_d;
  logic                     s1_last_q, s1_last_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]    s2_result_q, s2_result_d;
  logic                     s2_sat_q, s2_sat_d;
  logic                     s2_last_q, s2_last_d;
  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  logic [DATA_WIDTH-1:0] shift_result;
  logic                  shift_sat;
  logic                  s2_load;
  logic                  in_accept;

  sat_shift_left #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH)
  ) u_sat_shift_left (
    .x_i        (in_x),
    .exponent_i (in_exponent),
    .result_o   (shift_result),
    .sat_o      (shift_sat)
  );

  // S1 drains whenever S2 is empty or S2 is being consumed this cycle.
  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign in_accept = in_valid && in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_result_d = s1_result_q;
    s1_sat_d    = s1_sat_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_sat_d    = s2_sat_q;
    s2_last_d   = s2_last_q;
    sat_count_d = sat_count_q;

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_result_d = s1_result_q;
      s2_sat_d    = s1_sat_q;
      s2_last_d   = s1_last_q;
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end

    if (in_accept) begin
      s1_valid_d  = 1'b1;
      s1_result_d = shift_result;
      s1_sat_d    = shift_sat;
      s1_last_d   = in_last;
    end else if (s2_load) begin
      s1_valid_d  = 1'b0;
    end

    // Clear has priority over a coincident increment; the count sticks at all-ones.
    if (sat_count_clr) begin
      sat_count_d = '0;
    end else if (s2_valid_q && out_ready && s2_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s1_sat_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_sat_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_result_q <= s1_result_d;
      s1_sat_q    <= s1_sat_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_sat_q    <= s2_sat_d;
      s2_last_q   <= s2_last_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_result_q;
  assign out_saturated = s2_sat_q;
  assign out_last      = s2_last_q;
  assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_saturating_mul_by_pot_pipe.sv
// Scoreboard bench for saturating_mul_by_pot_pipe: directed beats push expected
// results; a negedge monitor pops and compares on every output handshake.
module tb_saturating_mul_by_pot_pipe;
  import npu_fixedpoint_pkg::*;

  localparam int DW = 32;
  localparam int EW = 5;
  localparam int CW = 16;

  typedef struct packed {
    sat_result_t res;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [EW-1:0] in_exponent;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_saturated;
  logic          out_last;
  logic [CW-1:0] sat_count;
  logic          sat_count_clr;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic held = 1'b0;
  logic [DW+1:0] held_val;
  logic stream_done;

  saturating_mul_by_pot_pipe #(
    .DATA_WIDTH(DW), .EXP_WIDTH(EW), .SAT_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_exponent(in_exponent), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_saturated(out_saturated), .out_last(out_last),
    .sat_count(sat_count), .sat_count_clr(sat_count_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Offer one beat (entered just after a posedge); push its expectation on accept.
  task automatic send(input logic [DW-1:0] x, input logic [EW-1:0] e, input logic last,
                      input logic [DW-1:0] r, input logic s);
    exp_t item;
    bit   ok = 1'b0;
    in_valid = 1'b1; in_x = x; in_exponent = e; in_last = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      item.res.result = r; item.res.sat = s; item.last = last;
      q.push_back(item);
    end else begin
      timeout_fail("send_accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  // Monitor: scoreboard compare on handshake, and data-hold check under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (held) check("hold_stable", {out_valid, out_last, out_saturated, out_result},
                      {1'b1, held_val});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %0h expected none", out_result);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("scoreboard", {out_last, out_saturated, out_result},
                {e.last, e.res.sat, e.res.result});
        end
      end
      held     <= out_valid && !out_ready;
      held_val <= {out_last, out_saturated, out_result};
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_exponent = '0; in_last = 1'b0;
    out_ready = 1'b0; sat_count_clr = 1'b0; stream_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    check("reset_out_sat_last", {out_saturated, out_last}, 64'd0);
    check("reset_sat_count", 64'(sat_count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Latency: out_valid appears two cycles after the accept cycle.
    out_ready = 1'b1;
    send(32'd1000, 5'd2, 1'b0, 32'd4000, 1'b0);
    @(negedge clk);
    check("latency_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    send(32'h4000_0000, 5'd1, 1'b0, INT32_MAX, 1'b1);
    drain();
    check("sat_count_1", 64'(sat_count), 64'd1);
    send(32'hC000_0000, 5'd1, 1'b0, INT32_MIN, 1'b0);
    send(32'hBFFF_FFFF, 5'd1, 1'b0, INT32_MIN, 1'b1);
    drain();
    check("sat_count_2", 64'(sat_count), 64'd2);

    // Boundary exponents.
    send(32'hFFFF_FFFF, 5'd31, 1'b0, INT32_MIN, 1'b0);
    send(32'd1,         5'd31, 1'b0, INT32_MAX, 1'b1);
    send(32'd100,       5'd0,  1'b0, 32'd100,   1'b0);
    send(32'd0,         5'd15, 1'b0, 32'd0,     1'b0);
    drain();
    check("sat_count_3", 64'(sat_count), 64'd3);

    // Fill both stages, then release: in_ready follows out_ready in the same cycle.
    out_ready = 1'b0;
    send(32'd5, 5'd1, 1'b0, 32'd10, 1'b0);
    send(32'd6, 5'd1, 1'b0, 32'd12, 1'b0);
    in_valid = 1'b1; in_x = 32'd7; in_exponent = 5'd1; in_last = 1'b0;
    @(negedge clk);
    check("full_in_ready_0", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("full_in_ready_1", {out_valid, in_ready}, 64'b10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);
    q.push_back('{res: '{result: 32'd14, sat: 1'b0}, last: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Backpressure stream with out_ready pattern 1,0,0,1 repeating.
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(DW'(i), 5'd4, (i == 8), DW'(i * 16), 1'b0);
        stream_done = 1'b1;
      end
      begin
        for (int k = 0; !stream_done; k++) begin
          out_ready = ((k % 4) == 0) || ((k % 4) == 3);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Clear coincident with a saturating output handshake: clear wins.
    out_ready = 1'b0;
    send(INT32_MAX, 5'd1, 1'b0, INT32_MAX, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    sat_count_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    sat_count_clr = 1'b0;
    check("clr_wins", 64'(sat_count), 64'd0);
    drain();

    // Reset mid-stream discards in-flight beats and clears the counter.
    send(INT32_MAX, 5'd1, 1'b0, INT32_MAX, 1'b1);
    drain();
    check("pre_reset_count", 64'(sat_count), 64'd1);
    out_ready = 1'b0;
    send(32'h4000_0000, 5'd1, 1'b0, INT32_MAX, 1'b1);
    send(32'hBFFF_FFFF, 5'd1, 1'b1, INT32_MIN, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_sat_count", 64'(sat_count), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'd3, 5'd1, 1'b0, 32'd6, 1'b0);
    drain();

    // Counter saturation: 2^16+5 clamped beats stick at all-ones.
    for (int i = 0; i < 65541; i++)
      send(INT32_MAX, 5'd31, 1'b0, INT32_MAX, 1'b1);
    drain();
    check("sat_count_sticky", 64'(sat_count), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
